// File: rtl/note_arbiter_if.sv
// Note arbiter key/handshake bundle: key levels and NoteReady flow in, the granted note and status flow out.
interface note_arbiter_if #(
    parameter int NUM_KEYS = 8,
    parameter int CODE_W   = 3
);
    logic [NUM_KEYS-1:0] KeyIn;
    logic                NoteReady;
    logic                NoteValid;
    logic [CODE_W-1:0]   NoteCode;
    logic [NUM_KEYS-1:0] Pending;
    logic                Overrun;

    modport master (
        output KeyIn, NoteReady,
        input  NoteValid, NoteCode, Pending, Overrun
    );

    modport slave (
        input  KeyIn, NoteReady,
        output NoteValid, NoteCode, Pending, Overrun
    );
endinterface

// File: rtl/note_arbiter.sv
// Round-robin key press arbiter: press-to-NoteValid is 2 cycles from IDLE, with GAP_CYCLES idle cycles after each grant.
// Backpressure: NoteValid/NoteCode hold until NoteReady is sampled high; presses keep accumulating in Pending meanwhile.
module note_arbiter #(
    parameter int NUM_KEYS   = 8,
    parameter int GAP_CYCLES = 4,
    parameter int CODE_W     = 3
) (
    input logic           Clock,
    input logic           Reset,
    note_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, OFFER, GAP} state_t;

    localparam logic [7:0] GAP_LOAD = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

    state_t              state;
    logic [NUM_KEYS-1:0] key_prev;
    logic [NUM_KEYS-1:0] pending;
    logic [NUM_KEYS-1:0] press;
    logic [NUM_KEYS-1:0] clear;
    logic [NUM_KEYS-1:0] pending_next;
    logic                overrun;
    logic                note_vld;
    logic                handshake;
    logic [CODE_W-1:0]   note_code;
    logic [CODE_W-1:0]   last_grant;
    logic [CODE_W-1:0]   next_code;
    logic [CODE_W-1:0]   idx;
    logic [7:0]          gap_cnt;

    assign press        = bus.KeyIn & ~key_prev;
    assign handshake    = (state == OFFER) & bus.NoteReady;
    assign clear        = handshake ? (NUM_KEYS'(1) << note_code) : '0;
    // A press landing on the clearing handshake re-arms the bit (set wins).
    assign pending_next = (pending & ~clear) | press;

    // Descending scan so the smallest offset after last_grant wins.
    always_comb begin
        next_code = '0;
        idx       = '0;
        for (int off = NUM_KEYS; off >= 1; off--) begin
            idx = CODE_W'((int'(last_grant) + off) % NUM_KEYS);
            if (pending[idx]) begin
                next_code = idx;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= IDLE;
            key_prev   <= bus.KeyIn;
            pending    <= '0;
            overrun    <= 1'b0;
            note_vld   <= 1'b0;
            note_code  <= '0;
            last_grant <= CODE_W'(NUM_KEYS - 1);
            gap_cnt    <= '0;
        end else begin
            key_prev <= bus.KeyIn;
            pending  <= pending_next;
            overrun  <= |(press & pending & ~clear);
            case (state)
                IDLE: begin
                    if (|pending) begin
                        note_code <= next_code;
                        note_vld  <= 1'b1;
                        state     <= OFFER;
                    end
                end
                OFFER: begin
                    if (bus.NoteReady) begin
                        last_grant <= note_code;
                        note_vld   <= 1'b0;
                        if (GAP_CYCLES == 0) begin
                            state <= IDLE;
                        end else begin
                            state   <= GAP;
                            gap_cnt <= GAP_LOAD;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == 8'd0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.NoteValid = note_vld;
    assign bus.NoteCode  = note_code;
    assign bus.Pending   = pending;
    assign bus.Overrun   = overrun;
endmodule
